// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage: state encodings,
// queue entry layout and the NOP used to fill pipeline bubbles.
package if_fetch_pkg;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [31:0] NOP_INST  = 32'h0000_0013;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_FETCH = 2'd1,
        IF_FLUSH = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory port of the fetch stage: single-outstanding req/ack with
// the request address held stable until the acknowledge arrives.
interface if_fetch_if;

    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_ack_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_ack_i,
        output mem_rdata_i
    );

endinterface

// File: rtl/if_queue.sv
// Small circular FIFO of {pc, inst} entries between the memory port and the
// decode output register; DEPTH must be a power of two so pointers wrap freely.
module if_queue
    import if_fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  fetch_entry_t  data_i,
    output fetch_entry_t  head_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; count_q alone decides which
    // entries are meaningful, so clearing the data would only cost flops.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

    assert property (@(posedge clk) disable iff (!rst)
        push_i && !flush_i |-> (count_q != CW'(DEPTH)) || pop_i);

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC generation, single-outstanding memory handshake,
// instruction queue and the registered {pc, inst} output to decode.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [31:0]       branch_target_address_i,
    if_fetch_if.master        mem,
    output logic [31:0]       pc_o,
    output logic [31:0]       inst_o,
    output logic              inst_valid_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [31:0] RESET_PC_ALIGNED = word_align(RESET_PC);

    if_state_e     state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic          req_q, req_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   inst_q, inst_d;
    logic          valid_q, valid_d;

    logic          redirect, fetch_ack, bypass;
    logic          q_push, q_pop, q_empty, space_after;
    logic [CW-1:0] q_count, count_after;
    fetch_entry_t  q_head, q_data;

    // A redirect seen while decode is stalled is ignored; decode re-presents it.
    assign redirect  = branch_flag_i && !stall_i;
    assign fetch_ack = (state_q == IF_FETCH) && mem.mem_ack_i;

    assign q_pop  = !stall_i && !redirect && !q_empty;
    assign bypass = !stall_i && !redirect && q_empty && fetch_ack;
    assign q_push = fetch_ack && !redirect && !bypass;
    assign q_data = '{pc: fetch_pc_q, inst: mem.mem_rdata_i};

    assign count_after = redirect ? '0
                       : q_count + CW'(q_push) - CW'(q_pop);
    assign space_after = (count_after < CW'(DEPTH));

    if_queue #(.DEPTH(DEPTH)) u_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .flush_i (redirect),
        .data_i  (q_data),
        .head_o  (q_head),
        .count_o (q_count),
        .empty_o (q_empty)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path through the
        // branches below leaves one unassigned and infers a latch.
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        valid_d    = valid_q;

        unique case (state_q)
            IF_IDLE:  if (redirect || space_after) state_d = IF_FETCH;
            IF_FETCH: begin
                if (!mem.mem_ack_i) begin
                    if (redirect) state_d = IF_FLUSH;
                end else if (!redirect && !space_after) begin
                    state_d = IF_IDLE;
                end
            end
            IF_FLUSH: if (mem.mem_ack_i) state_d = IF_FETCH;
            default:  state_d = IF_IDLE;
        endcase

        if (redirect)       fetch_pc_d = word_align(branch_target_address_i);
        else if (fetch_ack) fetch_pc_d = fetch_pc_q + 32'd4;

        if (!stall_i) begin
            if (q_pop) begin
                pc_d    = q_head.pc;
                inst_d  = q_head.inst;
                valid_d = 1'b1;
            end else if (bypass) begin
                pc_d    = fetch_pc_q;
                inst_d  = mem.mem_rdata_i;
                valid_d = 1'b1;
            end else begin
                inst_d  = NOP_INST;
                valid_d = 1'b0;
            end
        end
    end

    // An outstanding, unacknowledged request keeps its address even across a
    // redirect; the FLUSH state discards that data when it finally lands.
    assign req_addr_d = ((state_q != IF_IDLE) && !mem.mem_ack_i) ? req_addr_q
                                                                 : fetch_pc_d;
    assign req_d      = (state_d != IF_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IF_IDLE;
            fetch_pc_q <= RESET_PC_ALIGNED;
            req_addr_q <= RESET_PC_ALIGNED;
            req_q      <= 1'b0;
            pc_q       <= ZERO_WORD;
            inst_q     <= NOP_INST;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            req_q      <= req_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            valid_q    <= valid_d;
        end
    end

    assign mem.mem_req_o  = req_q;
    assign mem.mem_addr_o = req_addr_q;
    assign pc_o           = pc_q;
    assign inst_o         = inst_q;
    assign inst_valid_o   = valid_q;

    assert property (@(posedge clk) disable iff (!rst)
        req_q && !mem.mem_ack_i |=> req_q && $stable(req_addr_q));

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: a memory model with programmable ack delay
// feeds a scoreboard of expected {pc, inst} pairs, compared as decode sees them.
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_address_i = '0;
    logic [31:0] pc_o, inst_o;
    logic        inst_valid_o;

    if_fetch_if mem_if ();

    if_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall_i                 (stall_i),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .mem                     (mem_if),
        .pc_o                    (pc_o),
        .inst_o                  (inst_o),
        .inst_valid_o            (inst_valid_o)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] sb [$];
    int          epoch, req_epoch, wait_cnt, ack_delay;
    int          n_valid, n_acks, n_new_req;
    logic [31:0] last_req_addr;
    logic        prev_valid;
    logic [31:0] prev_pc, prev_inst;

    function automatic logic [31:0] inst_of(input logic [31:0] addr);
        return addr ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        epoch++;
        req_epoch  = -1;
        wait_cnt   = 0;
        n_valid    = 0;
        n_acks     = 0;
        prev_valid = 1'b0;
        prev_pc    = ZERO_WORD;
        prev_inst  = NOP_INST;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"},   mem_if.mem_req_o,  1'b0);
        check({tag, "_addr"},  mem_if.mem_addr_o, RESET_PC);
        check({tag, "_pc"},    pc_o,              ZERO_WORD);
        check({tag, "_inst"},  inst_o,            NOP_INST);
        check({tag, "_valid"}, inst_valid_o,      1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        stall_i = 1'b0;
        branch_flag_i = 1'b0;
        mem_if.mem_ack_i = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock: drive memory response, take the edge, update the model, check.
    task automatic tick();
        logic        req_b, acked, redir, stall_b;
        logic [31:0] addr_b;
        logic [63:0] e;
        req_b   = mem_if.mem_req_o;
        addr_b  = mem_if.mem_addr_o;
        mem_if.mem_ack_i   = req_b && (wait_cnt >= ack_delay);
        mem_if.mem_rdata_i = inst_of(addr_b);
        acked   = mem_if.mem_ack_i;
        stall_b = stall_i;
        redir   = branch_flag_i && !stall_i;
        @(posedge clk);
        if (acked) begin
            n_acks++;
            if (req_epoch == epoch && !redir) sb.push_back({addr_b, inst_of(addr_b)});
        end
        if (redir) begin
            epoch++;
            sb.delete();
        end
        if (req_b && !acked) wait_cnt++;
        #1;
        if (req_b && !acked) begin
            check("req_held",    mem_if.mem_req_o,  1'b1);
            check("addr_stable", mem_if.mem_addr_o, addr_b);
        end else if (mem_if.mem_req_o) begin
            req_epoch     = epoch;
            wait_cnt      = 0;
            last_req_addr = mem_if.mem_addr_o;
            n_new_req++;
            check("addr_align", last_req_addr & 32'h3, 32'h0);
        end
        if (stall_b) begin
            check("stall_hold", {inst_valid_o, pc_o, inst_o}, {prev_valid, prev_pc, prev_inst});
        end else if (inst_valid_o) begin
            n_valid++;
            if (sb.size() == 0) begin
                check("spurious_valid", inst_valid_o, 1'b0);
            end else begin
                e = sb.pop_front();
                check("out_pc",   pc_o,   e[63:32]);
                check("out_inst", inst_o, e[31:0]);
            end
        end
        if (!inst_valid_o) check("bubble_nop", inst_o, NOP_INST);
        prev_valid = inst_valid_o;
        prev_pc    = pc_o;
        prev_inst  = inst_o;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        int req_mark;
        epoch = 0;
        n_new_req = 0;
        mem_if.mem_ack_i = 1'b0;
        mem_if.mem_rdata_i = '0;

        // Zero-wait memory: one instruction per cycle from RESET_PC.
        do_reset();
        check_reset_vals("reset");
        ack_delay = 0;
        tick();
        check("first_req",  mem_if.mem_req_o,  1'b1);
        check("first_addr", mem_if.mem_addr_o, RESET_PC);
        tick();
        check("first_valid", inst_valid_o, 1'b1);
        check("first_pc",    pc_o,         RESET_PC);
        repeat (10) tick();
        check("throughput", n_valid, 11);
        check("t1_sb_empty", sb.size(), 0);

        // Slow memory: ack after three wait cycles, one instruction per four.
        do_reset();
        ack_delay = 3;
        repeat (40) tick();
        check("slow_rate", n_valid, 9);

        // Stall fills the queue to DEPTH, then drains in order.
        do_reset();
        ack_delay = 0;
        repeat (3) tick();
        check("pre_stall_pc", pc_o, 32'h4);
        stall_i = 1'b1;
        n_acks = 0;
        repeat (5) tick();
        check("stall_pushes",   n_acks,           DEPTH);
        check("stall_req_off",  mem_if.mem_req_o, 1'b0);
        check("stall_pc_frozen", pc_o,            32'h4);
        stall_i = 1'b0;
        n_valid = 0;
        repeat (8) tick();
        check("drain_rate", n_valid, 8);

        // Stalled branch ignored; accepted branch with same-edge ack drops the
        // queued entry and the acked word, and requests the aligned target.
        do_reset();
        ack_delay = 0;
        stall_i = 1'b1;
        repeat (2) tick();
        branch_flag_i = 1'b1;
        branch_target_address_i = 32'h300;
        tick();
        branch_flag_i = 1'b0;
        stall_i = 1'b0;
        tick();
        check("ignored_branch_pc", pc_o, RESET_PC);
        branch_flag_i = 1'b1;
        branch_target_address_i = 32'h203;
        tick();
        branch_flag_i = 1'b0;
        check("same_edge_bubble", inst_valid_o,      1'b0);
        check("same_edge_req",    mem_if.mem_req_o,  1'b1);
        check("same_edge_addr",   mem_if.mem_addr_o, 32'h200);
        repeat (4) tick();
        check("t4_sb_empty", sb.size(), 0);

        // Redirect while the request for 0x8 is still waiting for its ack.
        do_reset();
        ack_delay = 3;
        guard = 0;
        while (!(mem_if.mem_req_o && mem_if.mem_addr_o == 32'h8) && guard < 40) begin
            tick();
            guard++;
        end
        check("reach_req8", mem_if.mem_addr_o, 32'h8);
        tick();
        branch_flag_i = 1'b1;
        branch_target_address_i = 32'h100;
        tick();
        branch_flag_i = 1'b0;
        check("flush_bubble",    inst_valid_o,      1'b0);
        check("flush_addr_held", mem_if.mem_addr_o, 32'h8);
        req_mark = n_new_req;
        guard = 0;
        while (n_new_req == req_mark && guard < 10) begin
            tick();
            guard++;
        end
        check("redirect_target_req", last_req_addr, 32'h100);
        repeat (10) tick();
        check("t5_valid_seen", n_valid > 0, 1'b1);

        // Asynchronous reset in the middle of an outstanding request.
        do_reset();
        ack_delay = 3;
        repeat (5) tick();
        check("pre_rst_valid", inst_valid_o, 1'b1);
        check("pre_rst_req",   mem_if.mem_req_o, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals("async_rst");
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        ack_delay = 0;
        tick();
        check("refetch_addr", mem_if.mem_addr_o, RESET_PC);
        repeat (5) tick();
        check("refetch_valid", n_valid, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the RISC-V pipeline: generates the fetch PC, runs a single-outstanding req/ack handshake to instruction memory, buffers returned words in a small queue and presents one `{pc, inst}` per cycle to the decode stage through a registered output. Sits directly upstream of `id`, and consumes its `branch_flag_o`/`branch_target_address_o` redirect to squash wrong-path fetches.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `DEPTH`, 2, instruction queue entries (legal: 2 or 4)
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `stall_i`  in  1  decode not advancing; output register holds
- `branch_flag_i`  in  1  redirect request from `id`
- `branch_target_address_i`  in  32  redirect target; bits [1:0] ignored
- `mem_req_o`  out  1  fetch request to instruction memory
- `mem_addr_o`  out  32  word-aligned fetch address ([1:0]=00)
- `mem_ack_i`  in  1  request completes this cycle
- `mem_rdata_i`  in  32  instruction word, valid when `mem_req_o && mem_ack_i`
- `pc_o`  out  32  PC of instruction presented to `id`
- `inst_o`  out  32  instruction to `id`; NOP (32'h0000_0013) when invalid
- `inst_valid_o`  out  1  `inst_o` is a real fetched instruction

## Operation
- Fetch FSM states: IDLE (no request), FETCH (request for `fetch_pc` outstanding), FLUSH (request outstanding whose data must be discarded).
- IDLE→FETCH when queue occupancy (after this edge's pop) < DEPTH. FETCH on ack: push `{fetch_pc, mem_rdata_i}` (or bypass, below), `fetch_pc += 4`; stay FETCH if space remains, else IDLE. FLUSH on ack: discard data, →FETCH at `fetch_pc`.
- Request rule: once `mem_req_o` asserted, it and `mem_addr_o` stay constant until `mem_ack_i`; never withdrawn except by reset. `mem_addr_o = {fetch_pc[31:2],2'b00}`.
- Redirect accepted on an edge with `branch_flag_i=1 && stall_i=0`: queue flushed, `fetch_pc <= {target[31:2],2'b00}`, output register loads bubble; FSM: FETCH without ack→FLUSH, FETCH with same-edge ack→FETCH (ack data discarded), FLUSH→FLUSH, IDLE→FETCH.
- `branch_flag_i` while `stall_i=1` is ignored (output held; `id` re-presents it).
- Output register update, edge with `stall_i=0` and no redirect, priority: queue head (pop) → ack data bypass when queue empty and FSM in FETCH → bubble (`inst_valid_o=0`, `inst_o`=NOP, `pc_o` unchanged).
- `stall_i=1`: output holds; queue may still fill from acks up to DEPTH.
- Queue: circular, wrap-around pointers plus count; simultaneous push and pop when full is legal (no overflow since request gated on post-pop space).

## Timing
- Reset (async, any state): `mem_req_o=0`, `mem_addr_o=RESET_PC`, `pc_o=0`, `inst_o=32'h0000_0013`, `inst_valid_o=0`, queue empty, FSM IDLE, `fetch_pc=RESET_PC`. Request abandoned mid-flight; memory must tolerate it.
- First `mem_req_o` in cycle after reset deassertion edge.
- Ack at edge N with empty queue and no stall → valid at `inst_o` after edge N (0-cycle buffering latency).
- Redirect at edge N → target request issued from cycle N+1 (IDLE/FETCH) or after pending ack (FLUSH); at least one bubble.
- Zero-wait memory (ack tied high) sustains one instruction per cycle.

## Structure
- `defines.v`: `ZeroWord`, `InstAddrBus`, `InstBus`, `RstEnable` usage replaced by active-low compare here, new `NOP_INST` = 32'h0000_0013, FSM state encodings `IF_IDLE/IF_FETCH/IF_FLUSH`.
- Sub-module `if_queue`: DEPTH×64-bit FIFO with push, pop, flush, count, head; same async active-low reset.

## Test plan
- Reset, ack always 1 → addresses 0,4,8,… one per cycle; `pc_o`=0 valid cycle after first ack, then +4 per cycle.
- Ack delayed 3 cycles each → `mem_addr_o` stable while waiting; one valid instruction per 4 cycles, bubbles between.
- `stall_i=1` for 5 cycles, ack=1 → exactly DEPTH pushes then `mem_req_o=0`; outputs frozen; resume drains in order.
- Redirect to 32'h100 while request for 32'h8 pending (ack 2 cycles later) → 32'h8 data never appears at `inst_o`; next request addr 32'h100; queue contents dropped.
- Redirect with target 32'h203 on same edge as ack → ack discarded, `mem_addr_o`=32'h200.
- Assert `rst` low mid-request → all outputs at reset values immediately, refetch from `RESET_PC`.
